// File: rtl/dmem_result_checker.sv
`default_nettype none
// dmem_result_checker: snoops data-memory writes, captures result words and checks them against a
// loadable expected table. Optional readback ports enabled by DMEM_CHECKER_READBACK_EN. Rev 1.0
module dmem_result_checker #(
  parameter int          NUM_RESULTS    = 6,
  parameter logic [31:0] RESULT_BASE    = 32'h200,
  parameter logic [31:0] DONE_ADDR      = 32'h300,
  parameter logic [31:0] DONE_VALUE     = 32'h1,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter int          IDX_W          = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [31:0]                        d_mem_addr,
  input  logic [31:0]                        d_mem_wdata,
  input  logic [3:0]                         d_mem_wen,
  input  logic                               exp_we,
  input  logic [IDX_W-1:0]                   exp_idx,
  input  logic [31:0]                        exp_data,
`ifdef DMEM_CHECKER_READBACK_EN
  input  logic [IDX_W-1:0]                   rb_idx,
  output logic [31:0]                        rb_actual,
  output logic [31:0]                        rb_expected,
`endif
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               timed_out,
  output logic [$clog2(NUM_RESULTS+1)-1:0]   pass_count,
  output logic [NUM_RESULTS-1:0]             fail_mask,
  output logic [IDX_W-1:0]                   first_fail_idx,
  output logic [31:0]                        cycle_count
);

  localparam int                CNT_W        = $clog2(NUM_RESULTS + 1);
  localparam logic [32:0]       WIN_LO       = {1'b0, RESULT_BASE};
  localparam logic [32:0]       WIN_HI       = {1'b0, RESULT_BASE} + 33'(4 * NUM_RESULTS);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_RESULTS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT     = CNT_W'(NUM_RESULTS);
  localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  BASE_WORD    = RESULT_BASE[IDX_W+1:2];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      cap_mem [NUM_RESULTS];
  logic [31:0]      exp_mem [NUM_RESULTS];
  logic [IDX_W-1:0] chk_idx;

  logic             arm;
  logic             in_window;
  logic             cap_en;
  logic             exp_en;
  logic [IDX_W-1:0] wr_word;
  logic             done_hit;
  logic             timeout_hit;
  logic             chk_match;

  assign arm         = start && ((state == S_IDLE) || (state == S_DONE));
  assign in_window   = ({1'b0, d_mem_addr} >= WIN_LO) && ({1'b0, d_mem_addr} < WIN_HI);
  assign cap_en      = (state == S_RUN) && (d_mem_wen != 4'b0000) && in_window;
  assign exp_en      = exp_we && (state != S_CHECK);
  // Base is word aligned, so the low word-address bits alone give the offset inside the window.
  assign wr_word     = d_mem_addr[IDX_W+1:2] - BASE_WORD;
  assign done_hit    = (d_mem_wen == 4'b1111) && (d_mem_addr == DONE_ADDR) &&
                       (d_mem_wdata == DONE_VALUE);
  assign timeout_hit = (cycle_count == TIMEOUT_LAST);
  assign chk_match   = (cap_mem[chk_idx] == exp_mem[chk_idx]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (done_hit || timeout_hit) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (chk_idx == LAST_IDX) state_nxt = S_DONE;
      end
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result capture merges enabled bytes; the expected table survives re-arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_RESULTS; w++) begin
        cap_mem[w] <= '0;
        exp_mem[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_RESULTS; w++) begin
        if (arm) begin
          cap_mem[w] <= '0;
        end else if (cap_en && (wr_word == IDX_W'(w))) begin
          for (int b = 0; b < 4; b++) begin
            if (d_mem_wen[b]) cap_mem[w][8*b +: 8] <= d_mem_wdata[8*b +: 8];
          end
        end
        if (exp_en && (exp_idx == IDX_W'(w))) exp_mem[w] <= exp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_idx        <= '0;
      pass_count     <= '0;
      fail_mask      <= '0;
      first_fail_idx <= '0;
      cycle_count    <= '0;
      timed_out      <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            chk_idx        <= '0;
            pass_count     <= '0;
            fail_mask      <= '0;
            first_fail_idx <= '0;
            cycle_count    <= '0;
            timed_out      <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
          end
        end
        S_RUN: begin
          chk_idx <= '0;
          // The count freezes on the final RUN cycle; a done write beats a coincident timeout.
          if (!done_hit) begin
            if (timeout_hit)              timed_out   <= 1'b1;
            else if (cycle_count != '1)   cycle_count <= cycle_count + 32'd1;
          end
        end
        S_CHECK: begin
          if (chk_match) begin
            pass_count <= pass_count + CNT_W'(1);
          end else begin
            fail_mask[chk_idx] <= 1'b1;
            if (fail_mask == '0) first_fail_idx <= chk_idx;
          end
          chk_idx <= chk_idx + IDX_W'(1);
          if (chk_idx == LAST_IDX) begin
            done <= 1'b1;
            pass <= ((pass_count + CNT_W'(chk_match)) == FULL_CNT) && !timed_out;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_CHECKER_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_actual   <= '0;
      rb_expected <= '0;
    end else if (32'(rb_idx) < 32'(NUM_RESULTS)) begin
      rb_actual   <= cap_mem[rb_idx];
      rb_expected <= exp_mem[rb_idx];
    end else begin
      rb_actual   <= '0;
      rb_expected <= '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_result_checker.sv
`default_nettype none
`timescale 1ns/1ps
// tb_dmem_result_checker: directed and randomized checking of dmem_result_checker against a
// transaction-level model of the run/check sequence.
module tb_dmem_result_checker;
  localparam int N   = 6;
  localparam int TMO = 100;
  localparam int IW  = 3;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   d_mem_addr = '0;
  logic [31:0]   d_mem_wdata = '0;
  logic [3:0]    d_mem_wen = '0;
  logic          exp_we = 1'b0;
  logic [IW-1:0] exp_idx = '0;
  logic [31:0]   exp_data = '0;
  logic          busy, done, pass, timed_out;
  logic [CW-1:0] pass_count;
  logic [N-1:0]  fail_mask;
  logic [IW-1:0] first_fail_idx;
  logic [31:0]   cycle_count;
`ifdef DMEM_CHECKER_READBACK_EN
  logic [IW-1:0] rb_idx = '0;
  logic [31:0]   rb_actual, rb_expected;
`endif

  always #5 clk = ~clk;

  dmem_result_checker #(
    .NUM_RESULTS(N), .RESULT_BASE(32'h200), .DONE_ADDR(32'h300),
    .DONE_VALUE(32'h1), .TIMEOUT_CYCLES(TMO), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata), .d_mem_wen(d_mem_wen),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
`ifdef DMEM_CHECKER_READBACK_EN
    .rb_idx(rb_idx), .rb_actual(rb_actual), .rb_expected(rb_expected),
`endif
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .pass_count(pass_count), .fail_mask(fail_mask),
    .first_fail_idx(first_fail_idx), .cycle_count(cycle_count)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_CHECK, M_DONE} mphase_t;
  mphase_t     m_phase = M_IDLE;
  logic [31:0] m_cap [N];
  logic [31:0] m_exp [N];
  int          m_run = 0;
  bit          m_to = 0;
  int          m_left = 0;
  int          m_pc = 0, p_pc = 0;
  logic [N-1:0] m_mask = '0, p_mask = '0;
  int          m_ffi = 0, p_ffi = 0;
  bit          m_pass = 0, p_pass = 0;

  initial begin
    for (int i = 0; i < N; i++) begin m_cap[i] = '0; m_exp[i] = '0; end
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) begin m_cap[i] = '0; m_exp[i] = '0; end
        m_phase = M_IDLE; m_run = 0; m_to = 0; m_pc = 0; m_mask = '0; m_ffi = 0; m_pass = 0;
      end else begin
        if (exp_we && m_phase != M_CHECK && int'(exp_idx) < N) m_exp[exp_idx] = exp_data;
        case (m_phase)
          M_IDLE, M_DONE: if (start) begin
            for (int i = 0; i < N; i++) m_cap[i] = '0;
            m_run = 0; m_to = 0; m_pc = 0; m_mask = '0; m_ffi = 0; m_pass = 0;
            m_phase = M_RUN;
          end
          M_RUN: begin
            bit hit;
            if (d_mem_wen != 0 && d_mem_addr >= 32'h200 && d_mem_addr < 32'h200 + 4*N) begin
              int w;
              w = int'((d_mem_addr - 32'h200) / 4);
              for (int b = 0; b < 4; b++)
                if (d_mem_wen[b]) m_cap[w][8*b +: 8] = d_mem_wdata[8*b +: 8];
            end
            hit = (d_mem_wen == 4'hF) && (d_mem_addr == 32'h300) && (d_mem_wdata == 32'h1);
            if (hit || m_run == TMO - 1) begin
              bit found;
              m_to = !hit;
              p_pc = 0; p_mask = '0; p_ffi = 0; found = 0;
              for (int i = 0; i < N; i++) begin
                if (m_cap[i] == m_exp[i]) p_pc++;
                else begin
                  p_mask[i] = 1'b1;
                  if (!found) begin p_ffi = i; found = 1; end
                end
              end
              p_pass = (p_pc == N) && !m_to;
              m_left = N;
              m_phase = M_CHECK;
            end else begin
              m_run++;
            end
          end
          M_CHECK: begin
            m_left--;
            if (m_left == 0) begin
              m_pc = p_pc; m_mask = p_mask; m_ffi = p_ffi; m_pass = p_pass;
              m_phase = M_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("busy", 32'(busy), 32'(m_phase == M_RUN || m_phase == M_CHECK));
        check("done", 32'(done), 32'(m_phase == M_DONE));
        check("timed_out", 32'(timed_out), 32'(m_to));
        check("cycle_count", cycle_count, m_run);
        if (m_phase != M_CHECK) begin
          check("pass", 32'(pass), 32'(m_pass));
          check("pass_count", 32'(pass_count), m_pc);
          check("fail_mask", 32'(fail_mask), 32'(m_mask));
          check("first_fail_idx", 32'(first_fail_idx), m_ffi);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    d_mem_addr = a; d_mem_wdata = d; d_mem_wen = we;
    tick();
    d_mem_wen = '0;
  endtask

  task automatic load(input int i, input logic [31:0] v);
    exp_we = 1'b1; exp_idx = IW'(i); exp_data = v;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int edges);
    edges = 0;
    while (!done && edges < limit) begin tick(); edges++; end
    if (!done) check("wait_done_bound", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'd5;
      2: return 32'd42;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] vals [N];
  int lat;

  initial begin
    vals[0] = 32'd5; vals[1] = 32'd10; vals[2] = 32'd15;
    vals[3] = 32'd5; vals[4] = 32'd42; vals[5] = 32'hFFFF_FFF9;

    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass_count", 32'(pass_count), 0);
    check("rst_cycle_count", cycle_count, 0);

    // All words correct
    for (int i = 0; i < N; i++) load(i, vals[i]);
    arm();
    for (int i = 0; i < N; i++) bus(32'h200 + 32'(4*i), vals[i], 4'hF);
    bus(32'h300, 32'h1, 4'hF);
    wait_done(20, lat);
    check("A_latency", lat, 6);
    check("A_pass", 32'(pass), 1);
    check("A_pass_count", 32'(pass_count), 6);
    check("A_fail_mask", 32'(fail_mask), 0);
    check("A_cycle_count", cycle_count, 6);
`ifdef DMEM_CHECKER_READBACK_EN
    rb_idx = 3'd4; tick();
    check("A_rb_actual", rb_actual, 32'd42);
    check("A_rb_expected", rb_expected, 32'd42);
`endif

    // Word 3 wrong, re-armed from DONE
    arm();
    check("B_busy_after_start", 32'(busy), 1);
    check("B_done_cleared", 32'(done), 0);
    for (int i = 0; i < N; i++) bus(32'h200 + 32'(4*i), (i == 3) ? 32'd6 : vals[i], 4'hF);
    bus(32'h300, 32'h1, 4'hF);
    wait_done(20, lat);
    check("B_pass", 32'(pass), 0);
    check("B_pass_count", 32'(pass_count), 5);
    check("B_fail_mask", 32'(fail_mask), 32'b001000);
    check("B_first_fail_idx", 32'(first_fail_idx), 3);

    // Word 4 assembled from byte writes
    arm();
    for (int i = 0; i < N; i++) if (i != 4) bus(32'h200 + 32'(4*i), vals[i], 4'hF);
    bus(32'h210, 32'h0000_002A, 4'b0001);
    bus(32'h210, 32'h0000_0000, 4'b1110);
    bus(32'h300, 32'h1, 4'hF);
    wait_done(20, lat);
    check("C_pass", 32'(pass), 1);

    // Partial write to the done flag is ignored; run times out
    arm();
    for (int i = 0; i < N; i++) bus(32'h200 + 32'(4*i), vals[i], 4'hF);
    bus(32'h300, 32'h1, 4'b0001);
    wait_done(200, lat);
    check("D_timed_out", 32'(timed_out), 1);
    check("D_cycle_count", cycle_count, 99);
    check("D_pass", 32'(pass), 0);
    check("D_pass_count", 32'(pass_count), 6);

    // Late result write right before the flag, then re-arm from DONE
    arm();
    for (int i = 0; i < N; i++) if (i != 4) bus(32'h200 + 32'(4*i), vals[i], 4'hF);
    bus(32'h210, 32'd42, 4'hF);
    bus(32'h300, 32'h1, 4'hF);
    wait_done(20, lat);
    check("E_pass", 32'(pass), 1);
    arm();
    check("E_rearm_done", 32'(done), 0);
    check("E_rearm_pass_count", 32'(pass_count), 0);
    bus(32'h300, 32'h1, 4'hF);
    wait_done(20, lat);
    check("E_empty_fail_mask", 32'(fail_mask), 32'h3F);
    check("E_empty_pass", 32'(pass), 0);

    // Reset during CHECK, with start in the same cycle
    arm();
    bus(32'h300, 32'h1, 4'hF);
    tick(); tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("F_busy", 32'(busy), 0);
    check("F_done", 32'(done), 0);
    check("F_fail_mask", 32'(fail_mask), 0);
    check("F_cycle_count", cycle_count, 0);
`ifdef DMEM_CHECKER_READBACK_EN
    rb_idx = 3'd4; tick();
    check("F_rb_expected", rb_expected, 0);
    check("F_rb_actual", rb_actual, 0);
`endif

    // Randomized runs
    for (int it = 0; it < 30; it++) begin
      int len;
      for (int k = 0; k < int'($urandom_range(0, 8)); k++) load($urandom_range(0, 7), rand_word());
      arm();
      len = ($urandom_range(0, 3) == 0) ? 110 : int'($urandom_range(5, 60));
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: d_mem_addr = 32'h200 + $urandom_range(0, 4*N - 1);
          6:                d_mem_addr = 32'h300;
          7:                d_mem_addr = 32'h1F0 + $urandom_range(0, 63);
          default:          d_mem_addr = $urandom;
        endcase
        d_mem_wen   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        d_mem_wdata = (d_mem_addr == 32'h300 && $urandom_range(0, 1) == 1) ? 32'h1 : rand_word();
        exp_we      = ($urandom_range(0, 9) == 0);
        exp_idx     = IW'($urandom_range(0, 7));
        exp_data    = rand_word();
        start       = ($urandom_range(0, 19) == 0);
        tick();
        d_mem_wen = '0; exp_we = 1'b0; start = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) bus(32'h300, 32'h1, 4'hF);
      wait_done(250, lat);
    end

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
